// File: rtl/fetcher_pkg.sv
// fetcher_pkg: shared encodings for the per-SIMD-unit instruction fetcher.
//   fetch_state_t : fetcher FSM state encoding (exported on fetcher_state).
//   SIMD_*        : SIMD unit state encodings observed on simd_state.
package fetcher_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE    = 3'd0,
        FETCH_REQUEST = 3'd1,
        FETCH_DONE    = 3'd2
    } fetch_state_t;

    localparam logic [2:0] SIMD_IDLE    = 3'd0;
    localparam logic [2:0] SIMD_FETCH   = 3'd1;
    localparam logic [2:0] SIMD_DECODE  = 3'd2;
    localparam logic [2:0] SIMD_REQUEST = 3'd3;
    localparam logic [2:0] SIMD_WAIT    = 3'd4;
    localparam logic [2:0] SIMD_EXECUTE = 3'd5;
    localparam logic [2:0] SIMD_UPDATE  = 3'd6;
    localparam logic [2:0] SIMD_DONE    = 3'd7;

endpackage

// File: rtl/fetcher.sv
// fetcher: fetches one instruction word from program memory per SIMD fetch
// phase. One instance per SIMD unit, alongside that unit's PC.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : gates only the start of a new fetch
//   simd_state          : SIMD unit state (SIMD_FETCH starts, SIMD_DECODE releases)
//   DISPATCH_NEW_WAVE   : aborts any fetch, clears instruction
//   pc                  : address to fetch, sampled when the request starts
//   mem_read_valid/_address : program memory read request (held until ready)
//   mem_read_ready/_data    : read response, honoured only while requesting
//   fetcher_state       : current FSM state
//   instruction         : last fetched instruction word
module fetcher
    import fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
    parameter int PROGRAM_MEM_DATA_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [2:0]                        simd_state,
    input  logic                              DISPATCH_NEW_WAVE,
    input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc,
    output logic                              mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_read_address,
    input  logic                              mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_WIDTH-1:0] mem_read_data,
    output logic [2:0]                        fetcher_state,
    output logic [PROGRAM_MEM_DATA_WIDTH-1:0] instruction
);

    fetch_state_t                      state_q, state_d;
    logic                              valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [PROGRAM_MEM_DATA_WIDTH-1:0] instr_q, instr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;

        unique case (state_q)
            FETCH_IDLE: begin
                if (enable && (simd_state == SIMD_FETCH)) begin
                    state_d = FETCH_REQUEST;
                    valid_d = 1'b1;
                    addr_d  = pc;
                end
            end
            FETCH_REQUEST: begin
                // Address and valid are held regardless of pc/enable so the
                // request seen by memory never changes mid-transaction.
                if (mem_read_ready) begin
                    state_d = FETCH_DONE;
                    valid_d = 1'b0;
                    instr_d = mem_read_data;
                end
            end
            FETCH_DONE: begin
                if (simd_state == SIMD_DECODE) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // A new wave overrides everything, including a same-cycle ready.
        if (DISPATCH_NEW_WAVE) begin
            state_d = FETCH_IDLE;
            valid_d = 1'b0;
            instr_d = '0;
        end
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;

endmodule

// File: tb/tb_fetcher.sv
module tb_fetcher;
    import fetcher_pkg::*;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [2:0]    simd_state;
    logic          DISPATCH_NEW_WAVE;
    logic [AW-1:0] pc;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic [2:0]    fetcher_state;
    logic [DW-1:0] instruction;

    int checks   = 0;
    int failures = 0;

    fetcher #(
        .PROGRAM_MEM_ADDR_WIDTH(AW),
        .PROGRAM_MEM_DATA_WIDTH(DW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .simd_state        (simd_state),
        .DISPATCH_NEW_WAVE (DISPATCH_NEW_WAVE),
        .pc                (pc),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .fetcher_state     (fetcher_state),
        .instruction       (instruction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          en;
        logic [2:0]    simd;
        logic          disp;
        logic [AW-1:0] pc;
        logic          rdy;
        logic [DW-1:0] data;
        logic          e_valid;
        logic [AW-1:0] e_addr;
        logic [2:0]    e_state;
        logic [DW-1:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    // Program memory contents used by the hand-written sequences.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'h5A00 ^ {8'h00, 2'b00, a} ^ ({10'd0, a} << 8);
    endfunction

    task automatic add(input logic r, input logic e, input logic [2:0] s, input logic d,
                       input logic [AW-1:0] p, input logic rd, input logic [DW-1:0] dat,
                       input logic ev, input logic [AW-1:0] ea, input logic [2:0] es,
                       input logic [DW-1:0] ei);
        vec_t v;
        v.rst = r; v.en = e; v.simd = s; v.disp = d; v.pc = p; v.rdy = rd; v.data = dat;
        v.e_valid = ev; v.e_addr = ea; v.e_state = es; v.e_instr = ei;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] s, input logic d,
                         input logic [AW-1:0] p, input logic rd, input logic [DW-1:0] dat);
        rst = r; enable = e; simd_state = s; DISPATCH_NEW_WAVE = d;
        pc = p; mem_read_ready = rd; mem_read_data = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [AW-1:0] ea,
                           input logic [2:0] es, input logic [DW-1:0] ei);
        chk({tag, ".valid"}, 32'(mem_read_valid), 32'(ev));
        chk({tag, ".addr"},  32'(mem_read_address), 32'(ea));
        chk({tag, ".state"}, 32'(fetcher_state), 32'(es));
        chk({tag, ".instr"}, 32'(instruction), 32'(ei));
    endtask

    // Count request launches (valid rising) to confirm one request per fetch.
    int   req_count = 0;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (mem_read_valid && !valid_prev) req_count++;
        valid_prev <= mem_read_valid;
    end

    localparam logic [2:0] SI = 3'(FETCH_IDLE);
    localparam logic [2:0] SR = 3'(FETCH_REQUEST);
    localparam logic [2:0] SD = 3'(FETCH_DONE);

    initial begin
        int n;
        //    rst en simd        disp pc  rdy data      | valid addr state instr
        add(1, 0, SIMD_IDLE,    0, 0,  0, 16'h0000,   0, 0, SI, 16'h0000);  // reset
        add(0, 1, SIMD_FETCH,   0, 5,  1, 16'hA1B2,   1, 5, SR, 16'h0000);  // ready ignored in idle
        add(0, 1, SIMD_FETCH,   0, 5,  1, 16'hA1B2,   0, 5, SD, 16'hA1B2);  // best-case capture
        add(0, 1, SIMD_FETCH,   0, 5,  1, 16'hFFFF,   0, 5, SD, 16'hA1B2);  // stray ready in DONE
        add(0, 1, SIMD_DECODE,  0, 5,  0, 16'h0000,   0, 5, SI, 16'hA1B2);  // decode releases
        add(0, 0, SIMD_FETCH,   0, 7,  0, 16'h0000,   0, 5, SI, 16'hA1B2);  // enable=0 blocks
        add(0, 0, SIMD_FETCH,   0, 7,  1, 16'h1111,   0, 5, SI, 16'hA1B2);  // stray ready in IDLE
        add(0, 1, SIMD_FETCH,   0, 7,  0, 16'h0000,   1, 7, SR, 16'hA1B2);  // request addr 7
        add(0, 0, SIMD_EXECUTE, 0, 8,  0, 16'h0000,   1, 7, SR, 16'hA1B2);  // enable drop, pc moves
        add(0, 0, SIMD_EXECUTE, 0, 8,  1, 16'hBEEF,   0, 7, SD, 16'hBEEF);  // in-flight completes
        add(0, 1, SIMD_DECODE,  0, 8,  0, 16'h0000,   0, 7, SI, 16'hBEEF);
        add(0, 1, SIMD_FETCH,   0, 3,  0, 16'h0000,   1, 3, SR, 16'hBEEF);
        add(0, 1, SIMD_FETCH,   1, 4,  1, 16'hCAFE,   0, 3, SI, 16'h0000);  // dispatch beats ready
        add(0, 1, SIMD_FETCH,   0, 4,  0, 16'h0000,   1, 4, SR, 16'h0000);
        add(1, 1, SIMD_FETCH,   1, 9,  1, 16'h1234,   0, 0, SI, 16'h0000);  // rst mid-request
        add(0, 1, SIMD_FETCH,   0, 2,  0, 16'h0000,   1, 2, SR, 16'h0000);
        add(0, 1, SIMD_FETCH,   0, 2,  1, 16'h5555,   0, 2, SD, 16'h5555);
        add(0, 1, SIMD_FETCH,   1, 2,  0, 16'h0000,   0, 2, SI, 16'h0000);  // dispatch in DONE
        add(0, 1, SIMD_DECODE,  0, 6,  1, 16'h7777,   0, 2, SI, 16'h0000);  // no decode effect in IDLE

        rst = 1'b1; enable = 1'b0; simd_state = SIMD_IDLE; DISPATCH_NEW_WAVE = 1'b0;
        pc = '0; mem_read_ready = 1'b0; mem_read_data = '0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].simd, vecs[i].disp,
                  vecs[i].pc, vecs[i].rdy, vecs[i].data);
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_addr,
                    vecs[i].e_state, vecs[i].e_instr);
        end

        // Delayed ready while pc walks 5->9: request stays at address 5.
        drive(1, 0, SIMD_IDLE, 0, 0, 0, '0);
        drive(0, 1, SIMD_FETCH, 0, 5, 0, '0);
        chk_all("slow.start", 1, 5, SR, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, SIMD_FETCH, 0, AW'(6 + k), 0, 16'hDEAD);
            chk_all($sformatf("slow.hold%0d", k), 1, 5, SR, 16'h0000);
        end
        drive(0, 1, SIMD_FETCH, 0, 9, 1, mem_word(mem_read_address));
        chk_all("slow.done", 0, 5, SD, mem_word(6'd5));

        // Fetch/decode loop over pc 0,1,2 with one request each.
        drive(0, 1, SIMD_DECODE, 0, 9, 0, '0);
        chk("loop.idle", 32'(fetcher_state), 32'(SI));
        n = req_count;
        for (int p = 0; p < 3; p++) begin
            int waited;
            drive(0, 1, SIMD_FETCH, 0, AW'(p), 0, '0);
            chk_all($sformatf("loop%0d.req", p), 1, AW'(p), SR, mem_word(AW'(p) - 6'd1) & {DW{p != 0}} | (p == 0 ? mem_word(6'd5) : 16'h0000));
            // Ready arrives after a couple of idle cycles; bounded wait on DONE.
            waited = 0;
            while (fetcher_state != SD && waited < 10) begin
                chk($sformatf("loop%0d.single", p), 32'(mem_read_valid && fetcher_state == SR), 32'(fetcher_state == SR));
                drive(0, 1, SIMD_FETCH, 0, AW'(p + 7), waited >= 2, mem_word(mem_read_address));
                waited++;
            end
            chk($sformatf("loop%0d.timeout", p), 32'(waited <= 3), 32'd1);
            chk_all($sformatf("loop%0d.done", p), 0, AW'(p), SD, mem_word(AW'(p)));
            drive(0, 1, SIMD_DECODE, 0, AW'(p), 0, '0);
            chk($sformatf("loop%0d.release", p), 32'(fetcher_state), 32'(SI));
        end
        @(negedge clk);
        chk("loop.req_count", 32'(req_count - n), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
